// File: rtl/memory_access_if.sv
// Shared memory-stage types and the data-bus interface.
// Ports (memory_access_if): dreq (request to memory), dresp (response from memory).
package memory_access_pkg;
    typedef logic [63:0] word_t;
    typedef logic [63:0] addr_t;
    typedef logic [7:0]  strobe_t;
    typedef logic [2:0]  msize_t;

    typedef enum logic [3:0] {
        OP_ALU, OP_NONE,
        OP_LB, OP_LH, OP_LW, OP_LD,
        OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD
    } op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        addr_t       inst_pc;
        op_t         op;
        word_t       alu_result;
        word_t       write_mem_data;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        addr_t       inst_pc;
        op_t         op;
        word_t       result;
        logic        misaligned;
    } mem_wb_t;

    typedef struct packed {
        logic        reg_write_enable;
        logic [4:0]  reg_dest_addr;
        word_t       reg_write_data;
    } reg_writer_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;
endpackage

interface memory_access_if;
    memory_access_pkg::dbus_req_t  dreq;
    memory_access_pkg::dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/memory_access.sv
// Memory stage: issues loads/stores on the data bus, aligns load data.
// Ports: clk, reset (async low), ex_mem_state in, mem_wb_state/forward/ok out,
// dbus (master: dreq out, dresp in).
module memory_access
    import memory_access_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  ex_mem_t         ex_mem_state,
    output mem_wb_t         mem_wb_state,
    output reg_writer_t     forward,
    memory_access_if.master dbus,
    output logic            ok
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t  state, state_n;
    ex_mem_t lat_q;
    word_t   rdata_q;

    ex_mem_t cur;
    logic    is_load, is_store, signed_ld;
    msize_t  size;
    logic    is_mem, mis_raw, misal, writes_rd;
    logic    [2:0] off;
    logic    [5:0] sh_amt;
    strobe_t strb_base;
    word_t   sh, ld_res, result;
    logic    req_valid, ok_c, launch, capture;

    // Once the request has left IDLE, the latched copy drives everything.
    always_comb begin
        cur = (state == IDLE) ? ex_mem_state : lat_q;
    end

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        signed_ld = 1'b0;
        size      = 3'd0;
        unique case (cur.op)
            OP_LB:  begin is_load = 1'b1; signed_ld = 1'b1; end
            OP_LH:  begin is_load = 1'b1; signed_ld = 1'b1; size = 3'd1; end
            OP_LW:  begin is_load = 1'b1; signed_ld = 1'b1; size = 3'd2; end
            OP_LD:  begin is_load = 1'b1; size = 3'd3; end
            OP_LBU: begin is_load = 1'b1; end
            OP_LHU: begin is_load = 1'b1; size = 3'd1; end
            OP_LWU: begin is_load = 1'b1; size = 3'd2; end
            OP_SB:  begin is_store = 1'b1; end
            OP_SH:  begin is_store = 1'b1; size = 3'd1; end
            OP_SW:  begin is_store = 1'b1; size = 3'd2; end
            OP_SD:  begin is_store = 1'b1; size = 3'd3; end
            default: ;
        endcase
    end

    always_comb begin
        off    = cur.alu_result[2:0];
        sh_amt = {off, 3'b000};
        unique case (size)
            3'd0:    begin mis_raw = 1'b0;       strb_base = 8'h01; end
            3'd1:    begin mis_raw = off[0];     strb_base = 8'h03; end
            3'd2:    begin mis_raw = |off[1:0];  strb_base = 8'h0f; end
            default: begin mis_raw = |off;       strb_base = 8'hff; end
        endcase
        is_mem    = is_load | is_store;
        misal     = is_mem & mis_raw;
        writes_rd = (cur.op == OP_ALU) | is_load;
    end

    always_comb begin
        sh = rdata_q >> sh_amt;
        unique case (size)
            3'd0: ld_res = signed_ld ? {{56{sh[7]}}, sh[7:0]}
                                     : {56'b0, sh[7:0]};
            3'd1: ld_res = signed_ld ? {{48{sh[15]}}, sh[15:0]}
                                     : {48'b0, sh[15:0]};
            3'd2: ld_res = signed_ld ? {{32{sh[31]}}, sh[31:0]}
                                     : {32'b0, sh[31:0]};
            default: ld_res = sh;
        endcase
        result = is_load ? ld_res : cur.alu_result;
    end

    // ok and the request are gated by reset so nothing leaks while it is held.
    always_comb begin
        req_valid = (state == IDLE) & cur.valid & is_mem & ~misal & reset;
        unique case (state)
            IDLE:    ok_c = ~cur.valid | ~is_mem | misal;
            DONE:    ok_c = 1'b1;
            default: ok_c = 1'b0;
        endcase
        ok = ok_c & reset;
    end

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && dbus.dresp.addr_ok) begin
                    launch  = 1'b1;
                    capture = dbus.dresp.data_ok;
                    state_n = dbus.dresp.data_ok ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dbus.dresp.data_ok) begin
                    capture = 1'b1;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        dbus.dreq.valid  = req_valid;
        dbus.dreq.addr   = cur.alu_result;
        dbus.dreq.size   = size;
        dbus.dreq.strobe = is_store ? (strb_base << off) : 8'h00;
        dbus.dreq.data   = cur.write_mem_data << sh_amt;
    end

    always_comb begin
        mem_wb_state.valid      = cur.valid & ok;
        mem_wb_state.inst       = cur.inst;
        mem_wb_state.inst_pc    = cur.inst_pc;
        mem_wb_state.op         = cur.op;
        mem_wb_state.result     = result;
        mem_wb_state.misaligned = cur.valid & misal;
        forward.reg_write_enable = ok & cur.valid & writes_rd & ~misal;
        forward.reg_dest_addr    = cur.inst[11:7];
        forward.reg_write_data   = result;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lat_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (launch)  lat_q   <= ex_mem_state;
            if (capture) rdata_q <= dbus.dresp.data;
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access with a transaction-level reference model.
// Drives EX payloads and plays the memory side with random latencies.
module tb_memory_access;
    import memory_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    ex_mem_t     ex;
    mem_wb_t     wb;
    reg_writer_t fwd;
    logic        ok;

    memory_access_if dbus();

    memory_access dut (
        .clk(clk), .reset(reset), .ex_mem_state(ex),
        .mem_wb_state(wb), .forward(fwd), .dbus(dbus), .ok(ok)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit chk_en = 1'b0;
    bit e_ok, e_dv, e_valid, e_mis, e_we, e_res_chk, e_st;
    word_t e_addr, e_wdata, e_res;
    strobe_t e_strb;
    msize_t e_size;
    logic [31:0] e_inst;
    addr_t e_pc;
    op_t e_op;

    word_t   last_wdata;
    strobe_t last_strb;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ok", 64'(ok), 64'(e_ok));
            chk("dreq_valid", 64'(dbus.dreq.valid), 64'(e_dv));
            chk("wb_valid", 64'(wb.valid), 64'(e_ok & e_valid));
            chk("fwd_we", 64'(fwd.reg_write_enable), 64'(e_we));
            if (e_dv) begin
                chk("dreq_addr", dbus.dreq.addr, e_addr);
                chk("dreq_size", 64'(dbus.dreq.size), 64'(e_size));
                chk("dreq_strobe", 64'(dbus.dreq.strobe), 64'(e_strb));
                if (e_st) chk("dreq_data", dbus.dreq.data, e_wdata);
            end
            if (e_ok && e_valid) begin
                chk("wb_mis", 64'(wb.misaligned), 64'(e_mis));
                chk("wb_inst", 64'(wb.inst), 64'(e_inst));
                chk("wb_pc", wb.inst_pc, e_pc);
                chk("wb_op", 64'(wb.op), 64'(e_op));
                chk("fwd_rd", 64'(fwd.reg_dest_addr), 64'(e_inst[11:7]));
                if (e_res_chk) begin
                    chk("wb_result", wb.result, e_res);
                    chk("fwd_data", fwd.reg_write_data, e_res);
                end
            end
        end
        if (dbus.dreq.valid) begin
            last_wdata = dbus.dreq.data;
            last_strb  = dbus.dreq.strobe;
        end
    end

    // Access width in bytes (0 = no memory access), direction and signedness.
    function automatic void props(input op_t op, output int n, output bit ld,
                                  output bit st, output bit sg);
        n = 0; ld = 0; st = 0; sg = 0;
        case (op)
            OP_LB:  begin n = 1; ld = 1; sg = 1; end
            OP_LH:  begin n = 2; ld = 1; sg = 1; end
            OP_LW:  begin n = 4; ld = 1; sg = 1; end
            OP_LD:  begin n = 8; ld = 1; end
            OP_LBU: begin n = 1; ld = 1; end
            OP_LHU: begin n = 2; ld = 1; end
            OP_LWU: begin n = 4; ld = 1; end
            OP_SB:  begin n = 1; st = 1; end
            OP_SH:  begin n = 2; st = 1; end
            OP_SW:  begin n = 4; st = 1; end
            OP_SD:  begin n = 8; st = 1; end
            default: ;
        endcase
    endfunction

    function automatic word_t ld_model(word_t raw, int off, int n, bit sg);
        word_t v, m;
        v = raw >> (8 * off);
        m = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
        v = v & m;
        if (sg && v[8 * n - 1]) v = v | ~m;
        return v;
    endfunction

    function automatic word_t rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic ex_mem_t garbage();
        ex_mem_t g;
        g.valid = 1'($urandom_range(0, 1));
        g.inst = $urandom;
        g.inst_pc = rnd64();
        g.op = op_t'($urandom_range(0, 12));
        g.alu_result = rnd64();
        g.write_mem_data = rnd64();
        return g;
    endfunction

    // One EX payload, held until the stage completes. a = cycles before
    // addr_ok, d = extra cycles between addr_ok and data_ok.
    task automatic run_txn(input op_t op, input bit v, input word_t addr,
                           input word_t wdata, input logic [31:0] inst,
                           input int a, input int d, input word_t rdata);
        ex_mem_t t;
        int n, off, last_c;
        bit ld, st, sg, mis, mem;
        props(op, n, ld, st, sg);
        off = int'(addr[2:0]);
        mem = (n != 0);
        mis = mem && ((addr % 64'(n)) != 0);
        t.valid = v; t.inst = inst; t.inst_pc = rnd64(); t.op = op;
        t.alu_result = addr; t.write_mem_data = wdata;
        last_c = (v && mem && !mis) ? a + d + 1 : 0;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk); #1;
            ex = (last_c == 0 || c <= a) ? t : garbage();
            dbus.dresp.data = rnd64();
            dbus.dresp.addr_ok = 1'($urandom_range(0, 1));
            dbus.dresp.data_ok = 1'($urandom_range(0, 1));
            e_inst = t.inst; e_pc = t.inst_pc; e_op = op;
            e_addr = addr; e_size = msize_t'($clog2(n));
            e_strb = st ? strobe_t'(((1 << n) - 1) << off) : 8'h00;
            e_st = st; e_wdata = wdata << (8 * off);
            e_valid = v; e_mis = 0; e_res_chk = 0;
            e_ok = 0; e_dv = 0; e_we = 0;
            if (last_c == 0) begin
                e_ok = 1; e_mis = mem && mis;
                e_we = v && (op == OP_ALU || ld) && !mis;
                e_res_chk = !mem; e_res = addr;
            end else if (c < a) begin
                e_dv = 1;
                dbus.dresp.addr_ok = 1'b0;
            end else if (c == a) begin
                e_dv = 1;
                dbus.dresp.addr_ok = 1'b1;
                dbus.dresp.data_ok = (d == 0);
                if (d == 0) dbus.dresp.data = rdata;
            end else if (c < a + d) begin
                dbus.dresp.data_ok = 1'b0;
            end else if (c == a + d) begin
                dbus.dresp.data_ok = 1'b1;
                dbus.dresp.data = rdata;
            end else begin
                e_ok = 1; e_we = ld;
                e_res_chk = ld; e_res = ld_model(rdata, off, n, sg);
            end
            chk_en = 1'b1;
        end
        @(negedge clk); #1;
    endtask

    initial begin
        ex_mem_t t;
        ex = '0;
        ex.valid = 1'b1; ex.op = OP_ALU; ex.alu_result = 64'h5;
        dbus.dresp = '0;
        e_ok = 0; e_dv = 0; e_valid = 1; e_we = 0; e_st = 0; e_res_chk = 0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        run_txn(OP_ALU, 1, 64'h5, 64'h0, 32'h000001b3, 0, 0, 64'h0);
        chk("r018_ok", 64'(ok), 64'd1);
        chk("r018_result", wb.result, 64'h5);
        chk("r018_rd", 64'(fwd.reg_dest_addr), 64'd3);
        chk("r018_we", 64'(fwd.reg_write_enable), 64'd1);
        chk("r018_dv", 64'(dbus.dreq.valid), 64'd0);

        run_txn(OP_LB, 1, 64'h1003, 64'h0, 32'h00000283, 0, 0,
                64'h0000_0000_8000_0000);
        chk("r019_ok", 64'(ok), 64'd1);
        chk("r019_result", wb.result, 64'hffff_ffff_ffff_ff80);

        run_txn(OP_SH, 1, 64'h2002, 64'hbeef, 32'h00001023, 1, 3, 64'h0);
        chk("r020_data", last_wdata, 64'h0000_0000_beef_0000);
        chk("r020_strobe", 64'(last_strb), 64'h0c);
        chk("r020_ok", 64'(ok), 64'd1);

        run_txn(OP_LW, 1, 64'h3001, 64'h0, 32'h00002383, 0, 0, 64'h0);
        chk("r021_ok", 64'(ok), 64'd1);
        chk("r021_mis", 64'(wb.misaligned), 64'd1);
        chk("r021_we", 64'(fwd.reg_write_enable), 64'd0);
        chk("r021_dv", 64'(dbus.dreq.valid), 64'd0);

        for (int i = 0; i < 300; i++) begin
            word_t addr;
            addr = rnd64();
            if ($urandom_range(0, 1) == 1) addr[2:0] = 3'd0;
            run_txn(op_t'($urandom_range(0, 12)),
                    ($urandom_range(0, 9) != 0), addr, rnd64(), $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 3), rnd64());
        end

        // Reset while waiting for data; a late data_ok must not complete it.
        t = '0;
        t.valid = 1'b1; t.op = OP_LD; t.alu_result = 64'h4000;
        t.inst = 32'h00003403;
        @(posedge clk); #1;
        ex = t;
        dbus.dresp = '0; dbus.dresp.addr_ok = 1'b1;
        e_ok = 0; e_dv = 1; e_we = 0; e_valid = 1; e_st = 0;
        e_addr = 64'h4000; e_size = 3'd3; e_strb = 8'h00;
        @(posedge clk); #1;
        dbus.dresp.addr_ok = 1'b0;
        e_dv = 0;
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        dbus.dresp.data_ok = 1'b1; dbus.dresp.data = rnd64();
        e_dv = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("r022_ok", 64'(ok), 64'd0);
        chk("r022_we", 64'(fwd.reg_write_enable), 64'd0);
        run_txn(OP_LD, 1, 64'h4000, 64'h0, 32'h00003403, 0, 0,
                64'h0123_4567_89ab_cdef);
        chk("r022_done", wb.result, 64'h0123_4567_89ab_cdef);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase names them: clk and reset.
REQ-002 The block SHALL have no parameters; all widths SHALL come from the common package (word_t 64, addr_t 64, strobe 8, msize_t 3).
REQ-003 Ports, one per line, as name, direction, width, meaning:
- clk  in  1  clock.
- reset  in  1  async active-low reset.
- ex_mem_state  in  struct  EX result: valid, inst, inst_pc, op, alu_result (address or ALU value), write_mem_data.
- mem_wb_state  out  struct  WB payload: valid, inst, inst_pc, op, result, misaligned.
- forward  out  reg_writer  reg_write_enable, reg_dest_addr, reg_write_data, consumed by EX as forward1.
- dreq  out  dbus_req_t  valid, addr, size, strobe, data.
- dresp  in  dbus_resp_t  addr_ok, data_ok, data.
- ok  out  1  stage complete this cycle; upstream holds ex_mem_state until ok=1.

Function
REQ-004 The FSM SHALL have states IDLE, WAIT and DONE; reset SHALL force IDLE.
REQ-005 Non-memory op, or valid=0: ok=1 combinationally in IDLE; result=alu_result; no dreq; zero added latency.
REQ-006 Memory op in IDLE: dreq.valid=1 combinationally, addr=alu_result, size from op, data/strobe per REQ-009.
REQ-007 IDLE->DONE on addr_ok&data_ok in the same cycle; IDLE->WAIT on addr_ok only; otherwise stay in IDLE and hold dreq stable.
REQ-008 In WAIT: dreq.valid=0; ->DONE on data_ok. In DONE: ok=1, then ->IDLE next cycle. The captured load data register SHALL be written on the data_ok cycle.
REQ-009 Store data: write_mem_data shifted left by 8*addr[2:0]. Strobe: SB 1 bit, SH 2 bits, SW 4 bits, SD 8 bits, each shifted by addr[2:0]. Loads SHALL use strobe 0.
REQ-010 Load result: captured data shifted right by 8*addr[2:0], then extended. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD is taken as-is.
REQ-011 Misaligned access (LH/SH addr[0]!=0; LW/SW addr[1:0]!=0; LD/SD addr[2:0]!=0): no dreq; ok=1 in IDLE; misaligned=1; forward.reg_write_enable=0.
REQ-012 mem_wb_state.valid SHALL equal ex_mem_state.valid & ok; it SHALL be 0 whenever ok=0.
REQ-013 forward.reg_dest_addr=inst[11:7] and forward.reg_write_data=result. forward.reg_write_enable=1 only if ok=1, the op writes rd (ALU or load), and the access is not misaligned.
REQ-014 If ex_mem_state changes while the FSM is not in IDLE, the FSM SHALL ignore the change and finish the latched transaction. The address and op SHALL be latched on entry to WAIT.
REQ-015 data_ok arriving in IDLE with no outstanding request SHALL be ignored.

Reset
REQ-016 Reset values: state=IDLE, captured data=0, dreq.valid=0, ok=0 while reset is asserted, mem_wb_state.valid=0, forward.reg_write_enable=0.
REQ-017 Reset asserted in WAIT or DONE SHALL abort the transaction immediately; no ok or forward SHALL be produced for it after release.

Verification
REQ-018 ADD result 0x5, rd=3 -> same cycle: ok=1, mem_wb.result=0x5, forward enable=1 with rd=3, dreq.valid=0.
REQ-019 LB addr 0x1003, dresp data 0x00000000_80000000 with addr_ok&data_ok on cycle 1 -> DONE on cycle 2, result 0xFFFFFFFFFFFFFF80.
REQ-020 SH addr 0x2002, data 0xBEEF; addr_ok at cycle 1, data_ok at cycle 4 -> dreq.data 0x0000_0000_BEEF_0000, strobe 0x0C, dreq.valid=0 in WAIT, ok=1 only at cycle 5.
REQ-021 LW addr 0x3001 -> no dreq, ok=1, misaligned=1, forward enable=0.
REQ-022 LD issued, addr_ok received, reset asserted in WAIT, late data_ok arrives after release -> state IDLE, no ok, no forward.
